// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART transmitter: queues MMIO writes and drains them one byte
// at a time using a send strobe / done handshake.
module uart_tx_fifo_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              tx_done,
   input  logic              clr_overflow,
   output logic              tx_send_o,
   output logic [7:0]        tx_data_o,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              busy,
   output logic              overflow
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

   state_t            state_q, state_d;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              tx_send_q, tx_send_d;
   logic [7:0]        tx_data_q;
   logic              pop, push, drop;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign level     = count_q;
   assign busy      = (state_q != IDLE) || !empty;
   assign overflow  = overflow_q;
   assign tx_send_o = tx_send_q;
   assign tx_data_o = tx_data_q;

   always_comb begin
      pop  = (state_q == IDLE) && !empty;
      // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
      push = wr_en && (!full || pop);
      drop = wr_en && full && !pop;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + ONE_CNT;
      end else if (pop && !push) begin
         count_d = count_q - ONE_CNT;
      end

      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end

      state_d   = state_q;
      tx_send_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d   = SEND;
               tx_send_d = 1'b1;
            end
         end
         SEND: state_d = WAIT;
         WAIT: if (tx_done) state_d = GAP;
         // Wait for done to drop so a level-style done flag cannot retrigger.
         GAP:  if (!tx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_send_q  <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_send_q  <= tx_send_d;
         if (pop) begin
            tx_data_q <= mem[rd_ptr_q];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl: a constant vector table, directed
// sequences and randomized traffic compared every cycle against a queue-based model.
module tb_uart_tx_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, wr_en, tx_done, clr_overflow;
   logic [7:0] wr_data;
   logic       tx_send_o, full, empty, busy, overflow;
   logic [7:0] tx_data_o;
   logic [4:0] level;

   always #20 clk = ~clk;

   uart_tx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_done(tx_done),
      .clr_overflow(clr_overflow), .tx_send_o(tx_send_o), .tx_data_o(tx_data_o),
      .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queued bytes plus the state of the outstanding handshake.
   logic [7:0] m_q[$];
   bit         link_busy = 0;
   int         send_cyc  = 0;
   int         hi_cyc    = -1;
   int         cyc       = 0;
   logic [7:0] m_data    = 8'h00;
   bit         m_ovf     = 0;
   bit         exp_send  = 0;
   logic [7:0] sent_log[$];

   // Transmitter stand-in for the directed tests.
   int since_send = -1;
   int resp_delay = 10;
   int resp_hold  = 1;
   bit stalled    = 0;

   typedef struct {
      bit         r, w;
      logic [7:0] d;
      bit         dn, c;
      bit         e_send;
      logic [7:0] e_data;
      int         e_level;
      bit         e_busy;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input bit w, input logic [7:0] d, input bit dn, input bit c);
      bit was_busy, pop_now, dropped;
      int sz;
      rst = r; wr_en = w; wr_data = d; tx_done = dn; clr_overflow = c;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_q.delete();
         link_busy = 0; hi_cyc = -1; m_data = 8'h00; m_ovf = 0; exp_send = 0;
      end else begin
         was_busy = link_busy;
         sz = m_q.size();
         // Done counts only once the strobe cycle is over; then it must fall again.
         if (was_busy) begin
            if (hi_cyc < 0) begin
               if (cyc >= send_cyc + 2 && dn) hi_cyc = cyc;
            end else if (!dn) begin
               link_busy = 0;
            end
         end
         pop_now = !was_busy && sz > 0;
         if (pop_now) begin
            m_data = m_q.pop_front();
            link_busy = 1; send_cyc = cyc; hi_cyc = -1;
         end
         dropped = w && sz >= 16 && !pop_now;
         if (w && !dropped) m_q.push_back(d);
         if (dropped) m_ovf = 1;
         else if (c)  m_ovf = 0;
         exp_send = pop_now;
      end
      #1;
      chk("send",     tx_send_o, exp_send);
      chk("data",     tx_data_o, m_data);
      chk("level",    level,     m_q.size());
      chk("full",     full,      m_q.size() == 16);
      chk("empty",    empty,     m_q.size() == 0);
      chk("busy",     busy,      link_busy || m_q.size() > 0);
      chk("overflow", overflow,  m_ovf);
      if (tx_send_o) sent_log.push_back(tx_data_o);
   endtask

   task automatic tick(input bit w, input logic [7:0] d, input bit c);
      bit dn;
      dn = !stalled && since_send >= resp_delay && since_send < resp_delay + resp_hold;
      step(1'b0, w, d, dn, c);
      if (tx_send_o) since_send = 0;
      else if (since_send >= 0) since_send++;
   endtask

   initial begin
      logic [7:0] hola[4];
      int n0, written, tries;
      bit seen;
      hola[0] = 8'h48; hola[1] = 8'h4F; hola[2] = 8'h4C; hola[3] = 8'h41;

      //            r  w  d      dn c  send data   lvl busy
      tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
      tbl[1]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
      tbl[2]  = '{0, 1, 8'h41, 0, 0, 0, 8'h00, 1, 1};
      tbl[3]  = '{0, 0, 8'h00, 0, 0, 1, 8'h41, 0, 1};
      tbl[4]  = '{0, 0, 8'h00, 0, 0, 0, 8'h41, 0, 1};
      tbl[5]  = '{0, 0, 8'h00, 1, 0, 0, 8'h41, 0, 1};
      tbl[6]  = '{0, 0, 8'h00, 1, 0, 0, 8'h41, 0, 1};
      tbl[7]  = '{0, 0, 8'h00, 0, 0, 0, 8'h41, 0, 0};
      tbl[8]  = '{0, 1, 8'h42, 0, 0, 0, 8'h41, 1, 1};
      tbl[9]  = '{0, 0, 8'h00, 1, 0, 1, 8'h42, 0, 1};
      tbl[10] = '{0, 0, 8'h00, 1, 0, 0, 8'h42, 0, 1};
      tbl[11] = '{0, 0, 8'h00, 0, 0, 0, 8'h42, 0, 1};
      tbl[12] = '{0, 0, 8'h00, 1, 0, 0, 8'h42, 0, 1};
      tbl[13] = '{0, 0, 8'h00, 0, 0, 0, 8'h42, 0, 0};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].dn, tbl[i].c);
         chk($sformatf("tbl%0d_send", i),  tx_send_o, tbl[i].e_send);
         chk($sformatf("tbl%0d_data", i),  tx_data_o, tbl[i].e_data);
         chk($sformatf("tbl%0d_level", i), level,     tbl[i].e_level);
         chk($sformatf("tbl%0d_busy", i),  busy,      tbl[i].e_busy);
         $display("vec %0d send=%0d data=%02h level=%0d busy=%0d", i, tx_send_o, tx_data_o, level, busy);
      end

      // Reset, then stay quiet for 100 cycles.
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      chk("rst_data", tx_data_o, 0);
      chk("rst_empty", empty, 1);
      n0 = sent_log.size();
      repeat (100) tick(0, 8'h00, 0);
      chk("quiet_sends", sent_log.size() - n0, 0);
      $display("txn reset+quiet done");

      // Single byte with done 10 cycles after the strobe.
      sent_log.delete();
      tick(1, 8'h41, 0);
      repeat (30) tick(0, 8'h00, 0);
      chk("single_count", sent_log.size(), 1);
      if (sent_log.size() == 1) chk("single_byte", sent_log[0], 8'h41);
      chk("single_idle", busy, 0);
      $display("txn single byte sent=%0d", sent_log.size());

      // "HOLA" burst with a pulse done, then with done held high for 5 cycles.
      for (int pass = 0; pass < 2; pass++) begin
         resp_delay = pass ? 3 : 4;
         resp_hold  = pass ? 5 : 1;
         sent_log.delete();
         for (int i = 0; i < 4; i++) tick(1, hola[i], 0);
         repeat (80) tick(0, 8'h00, 0);
         chk("hola_count", sent_log.size(), 4);
         for (int i = 0; i < 4 && i < sent_log.size(); i++) chk("hola_byte", sent_log[i], hola[i]);
         chk("hola_level", level, 0);
         $display("txn hola pass %0d strobes=%0d", pass, sent_log.size());
      end

      // Stalled transmitter: one byte in flight, 16 queued, the next write dropped.
      stalled = 1;
      resp_hold = 1;
      for (int i = 0; i < 18; i++) tick(1, 8'h60 + 8'(i), 0);
      chk("stall_full", full, 1);
      chk("stall_level", level, 16);
      chk("stall_ovf", overflow, 1);
      tick(0, 8'h00, 1);
      chk("clr_ovf", overflow, 0);
      $display("txn overflow+clear level=%0d", level);

      // Push into a full FIFO on the very cycle it pops.
      stalled = 0; resp_delay = 2; since_send = 2;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (!link_busy && m_q.size() == 16) begin
            tick(1, 8'hA0, 0);
            chk("fullpop_level", level, 16);
            chk("fullpop_ovf", overflow, 0);
            seen = 1;
         end else begin
            tick(0, 8'h00, 0);
         end
      end
      chk("fullpop_seen", seen, 1);
      repeat (300) tick(0, 8'h00, 0);
      $display("txn full push+pop seen=%0d", seen);

      // 40 bytes through the FIFO to exercise pointer wrap.
      sent_log.delete();
      resp_delay = 1;
      written = 0; tries = 0;
      while (written < 40 && tries < 2000) begin
         tries++;
         if (m_q.size() < 15 && ($urandom_range(0, 3) != 0)) begin
            tick(1, 8'h10 + 8'(written), 0);
            written++;
         end else begin
            tick(0, 8'h00, 0);
         end
      end
      repeat (400) tick(0, 8'h00, 0);
      chk("wrap_count", sent_log.size(), 40);
      for (int i = 0; i < 40 && i < sent_log.size(); i++) chk("wrap_byte", sent_log[i], 8'h10 + i);
      $display("txn wrap 40 sent=%0d", sent_log.size());

      // Reset while waiting on done with 5 bytes queued.
      stalled = 1;
      for (int i = 0; i < 6; i++) tick(1, 8'hC0 + 8'(i), 0);
      chk("pre_rst_level", level, 5);
      step(1, 0, 8'h00, 0, 0);
      stalled = 0;
      n0 = sent_log.size();
      repeat (30) tick(0, 8'h00, 0);
      chk("post_rst_level", level, 0);
      chk("post_rst_data", tx_data_o, 0);
      chk("post_rst_sends", sent_log.size() - n0, 0);
      $display("txn reset mid-transfer level=%0d", level);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 4) < 2, 8'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end
      $display("txn random 3000 cycles done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
